// File: rtl/opsum_ppu.sv
// opsum_ppu: requantizes the PE-array opsum stream to int8, packs four results per word and writes them to the GLB.
// Optional feature: define OPSUM_PPU_RELU_EN to clamp negative scaled values to zero before the zero-point add.
module opsum_ppu #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [ADDR_BITS-1:0] cfg_base_addr,
    input  logic [ADDR_BITS-1:0] cfg_num_opsum,
    input  logic [15:0]          cfg_scale,
    input  logic [4:0]           cfg_shift,
    input  logic [7:0]           cfg_zero_point,
    input  logic                 opsum_valid,
    output logic                 opsum_ready,
    input  logic [DATA_SIZE-1:0] opsum_data,
    output logic                 glb_we,
    input  logic                 glb_wready,
    output logic [ADDR_BITS-1:0] glb_addr,
    output logic [DATA_SIZE-1:0] glb_wdata,
    output logic                 busy,
    output logic                 done
);
    localparam int P = DATA_SIZE + 17;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t r_state;
    logic [ADDR_BITS-1:0] r_num, r_acc, r_addr;
    logic [15:0] r_scale;
    logic [4:0] r_shift;
    logic [7:0] r_zp;
    logic r_busy, r_done, r_s1_v, r_s1_last, r_s2_v, r_s2_last, r_we, r_we_last;
    logic signed [P-1:0] r_s1_p;
    logic [7:0] r_s2_y;
    logic [1:0] r_lane;
    logic [DATA_SIZE-1:0] r_word, r_wdata;
    logic w_stall, w_acc, w_hs, w_last, w_emit;
    logic signed [P:0] w_rnd, w_sum, w_r, w_rr, w_y;
    logic [7:0] w_sat;
    logic [DATA_SIZE-1:0] w_word;

    assign w_stall     = r_we && !glb_wready;
    assign w_hs        = r_we && glb_wready;
    assign opsum_ready = (r_state == RUN) && (r_acc < r_num) && !w_stall;
    assign w_acc       = opsum_valid && opsum_ready;
    assign w_last      = r_acc + ADDR_BITS'(1) == r_num;
    assign w_emit      = r_s2_v && !w_stall && (r_lane == 2'd3 || r_s2_last);
    assign w_word      = r_word | (DATA_SIZE'(r_s2_y) << {r_lane, 3'b000});
    assign glb_we      = r_we;
    assign glb_addr    = r_addr;
    assign glb_wdata   = r_wdata;
    assign busy        = r_busy;
    assign done        = r_done;

    // Requantization of the S1 product: round, arithmetic shift, optional ReLU, zero point, saturate.
    always_comb begin
        w_rnd = (r_shift == 5'd0) ? '0 : ((P+1)'(1) <<< (r_shift - 5'd1));
        w_sum = {r_s1_p[P-1], r_s1_p} + w_rnd;
        w_r   = w_sum >>> r_shift;
`ifdef OPSUM_PPU_RELU_EN
        w_rr  = w_r[P] ? '0 : w_r;
`else
        w_rr  = w_r;
`endif
        w_y   = w_rr + {{(P-7){r_zp[7]}}, r_zp};
        w_sat = (w_y > (P+1)'(127)) ? 8'h7f : (w_y < -(P+1)'(128)) ? 8'h80 : w_y[7:0];
    end

    // Job control FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_acc   <= '0;
            r_num   <= '0;
            r_scale <= '0;
            r_shift <= '0;
            r_zp    <= '0;
        end else begin
            case (r_state)
                IDLE: if (cfg_start) begin
                    r_num   <= cfg_num_opsum;
                    r_scale <= cfg_scale;
                    r_shift <= cfg_shift;
                    r_zp    <= cfg_zero_point;
                    r_acc   <= '0;
                    r_state <= (cfg_num_opsum == '0) ? DONE : RUN;
                    r_busy  <= cfg_num_opsum != '0;
                    r_done  <= cfg_num_opsum == '0;
                end
                RUN: if (w_acc) begin
                    r_acc <= r_acc + ADDR_BITS'(1);
                    if (w_last) r_state <= FLUSH;
                end
                FLUSH: if (w_hs && r_we_last) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Two-stage arithmetic pipeline; frozen while a write is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_p    <= '0;
            r_s2_v    <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_y    <= '0;
        end else if (!w_stall) begin
            r_s1_v    <= w_acc;
            r_s1_last <= w_acc && w_last;
            if (w_acc) r_s1_p <= $signed(opsum_data) * $signed({1'b0, r_scale});
            r_s2_v    <= r_s1_v;
            r_s2_last <= r_s1_last;
            r_s2_y    <= w_sat;
        end
    end

    // Byte packer and GLB write port; a word goes out on lane 3 or on the job's final element.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane    <= '0;
            r_word    <= '0;
            r_we      <= 1'b0;
            r_we_last <= 1'b0;
            r_wdata   <= '0;
            r_addr    <= '0;
        end else begin
            if (r_state == IDLE && cfg_start) r_addr <= cfg_base_addr;
            else if (w_hs) r_addr <= r_addr + ADDR_BITS'(1);
            if (!w_stall) r_we <= w_emit;
            if (w_emit) begin
                r_wdata   <= w_word;
                r_we_last <= r_s2_last;
            end
            if (r_s2_v && !w_stall) begin
                r_word <= w_emit ? '0 : w_word;
                r_lane <= w_emit ? 2'd0 : r_lane + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_opsum_ppu.sv
// tb_opsum_ppu: scoreboard bench for opsum_ppu; expected words queued at stimulus time, compared on each GLB write.
module tb_opsum_ppu;
    typedef int iq_t[$];
    typedef struct {logic [15:0] a; logic [31:0] d;} wr_t;

    logic        clk = 0, rst = 1, cfg_start = 0, opsum_valid = 0, glb_wready = 1;
    logic [15:0] cfg_base_addr = 0, cfg_num_opsum = 0, cfg_scale = 0;
    logic [4:0]  cfg_shift = 0;
    logic [7:0]  cfg_zero_point = 0;
    logic [31:0] opsum_data = 0;
    logic        opsum_ready, glb_we, busy, done;
    logic [15:0] glb_addr;
    logic [31:0] glb_wdata;

    int checks = 0, errors = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, we_rise = 0;
    logic prev_we = 0;
    wr_t sb[$];
    wr_t e_m;

    opsum_ppu dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_num_opsum(cfg_num_opsum), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .cfg_zero_point(cfg_zero_point), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
        .opsum_data(opsum_data), .glb_we(glb_we), .glb_wready(glb_wready), .glb_addr(glb_addr),
        .glb_wdata(glb_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (glb_we && glb_wready) begin
            wr_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: addr=%h data=%h, required no write", glb_addr, glb_wdata);
            end else begin
                e_m = sb.pop_front();
                if (glb_addr !== e_m.a || glb_wdata !== e_m.d) begin
                    errors++;
                    $display("FAIL write_data: addr=%h data=%h, required addr=%h data=%h", glb_addr, glb_wdata, e_m.a, e_m.d);
                end
            end
        end
        if (glb_we && !prev_we) we_rise = cyc;
        prev_we = glb_we;
        if (done) done_cnt++;
    end

    function automatic logic [7:0] model(input int d, input int sc, input int sh, input int zp);
        longint r;
        r = longint'(d) * longint'(sc);
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
`ifdef OPSUM_PPU_RELU_EN
        if (r < 0) r = 0;
`endif
        r = r + longint'(zp);
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
        return r[7:0];
    endfunction

    task automatic push_expected(input logic [15:0] base, input int sc, input int sh, input int zp, input iq_t ops);
        logic [31:0] w = 0;
        logic [15:0] a = base;
        for (int k = 0; k < ops.size(); k++) begin
            w = w | (32'(model(ops[k], sc, sh, zp)) << (8 * (k % 4)));
            if (k % 4 == 3 || k == ops.size() - 1) begin
                sb.push_back('{a, w});
                a = a + 16'd1;
                w = 0;
            end
        end
    endtask

    task automatic start_job(input logic [15:0] base, input logic [15:0] num, input int sc, input int sh, input int zp);
        wr_cnt = 0;
        done_cnt = 0;
        cfg_base_addr = base;
        cfg_num_opsum = num;
        cfg_scale = sc[15:0];
        cfg_shift = sh[4:0];
        cfg_zero_point = zp[7:0];
        cfg_start = 1;
        @(posedge clk); #1;
        cfg_start = 0;
    endtask

    task automatic send_all(input iq_t ops, output int first, output int last);
        int n;
        first = 0;
        last = 0;
        for (int i = 0; i < ops.size(); i++) begin
            opsum_valid = 1;
            opsum_data = ops[i];
            n = 0;
            @(negedge clk);
            while (!opsum_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!opsum_ready) begin
                errors++;
                $display("FAIL accept[%0d]: opsum_ready=0 after %0d cycles, required 1", i, n);
                opsum_valid = 0;
                return;
            end
            if (i == 0) first = cyc;
            last = cyc;
            @(posedge clk); #1;
        end
        opsum_valid = 0;
    endtask

    task automatic wait_done(input string name, input int exp_w);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 300);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done: done=0 after %0d cycles, required 1", name, n);
        end
        checks++;
        if (wr_cnt !== exp_w) begin
            errors++;
            $display("FAIL %s_writes: got %0d, required %0d", name, wr_cnt, exp_w);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d words never written, required 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (opsum_ready !== 0) begin errors++; $display("FAIL rst_ready: got %b, required 0", opsum_ready); end
        if (glb_we !== 0) begin errors++; $display("FAIL rst_we: got %b, required 0", glb_we); end
        if (glb_addr !== 0) begin errors++; $display("FAIL rst_addr: got %h, required 0", glb_addr); end
        if (glb_wdata !== 0) begin errors++; $display("FAIL rst_wdata: got %h, required 0", glb_wdata); end
        if (busy !== 0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (done !== 0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_pack();
        int f, l;
        sb.push_back('{16'h0010, 32'h04030201});
        start_job(16'h0010, 16'd4, 1, 0, 0);
        checks++;
        if (busy !== 1) begin errors++; $display("FAIL basic_busy: got %b, required 1", busy); end
        send_all('{1, 2, 3, 4}, f, l);
        wait_done("basic", 1);
        checks++;
        if (we_rise - l !== 3) begin errors++; $display("FAIL basic_latency: got %0d, required 3", we_rise - l); end
        @(negedge clk);
        checks += 2;
        if (done !== 0 || done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulse: done=%b count=%0d, required 0 and 1", done, done_cnt); end
        if (busy !== 0) begin errors++; $display("FAIL basic_busy_end: got %b, required 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_sat();
        int f, l, sc, sh, zp;
        iq_t ops;
`ifdef OPSUM_PPU_RELU_EN
        sb.push_back('{16'h0100, 32'h00007F04});
`else
        sb.push_back('{16'h0100, 32'hFE807F04});
`endif
        start_job(16'h0100, 16'd4, 3, 2, 0);
        send_all('{5, 1000, -1000, -3}, f, l);
        wait_done("round", 1);
`ifdef OPSUM_PPU_RELU_EN
        sb.push_back('{16'h0200, 32'h05500505});
`else
        sb.push_back('{16'h0200, 32'h04500503});
`endif
        start_job(16'h0200, 16'd4, 3, 2, 5);
        send_all('{-3, 0, 100, -1}, f, l);
        wait_done("zp", 1);
        sc = $urandom_range(65535);
        sh = $urandom_range(31);
        zp = $signed(8'($urandom));
        for (int i = 0; i < 11; i++) ops.push_back(int'($urandom));
        push_expected(16'h0300, sc, sh, zp, ops);
        start_job(16'h0300, 16'd11, sc, sh, zp);
        send_all(ops, f, l);
        wait_done("random", 3);
        checks++;
        if (l - f !== 10) begin errors++; $display("FAIL back_to_back: span %0d cycles, required 10", l - f); end
    endtask

    task automatic test_partial_tail();
        int f, l;
        sb.push_back('{16'hFFFF, 32'h04030201});
        sb.push_back('{16'h0000, 32'h00000605});
        start_job(16'hFFFF, 16'd6, 1, 0, 0);
        send_all('{1, 2, 3, 4, 5, 6}, f, l);
        wait_done("tail", 2);
    endtask

    task automatic test_backpressure();
        int f, l, n;
        iq_t ops = '{17, -9, 88, 127, -128, 3, 64, -77, 12, 99, -1, 42};
        logic [15:0] a0;
        logic [31:0] d0;
        push_expected(16'h0400, 1, 0, 0, ops);
        glb_wready = 0;
        start_job(16'h0400, 16'd12, 1, 0, 0);
        fork
            send_all(ops, f, l);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!glb_we && n < 50);
                checks++;
                if (!glb_we) begin errors++; $display("FAIL bp_pending: glb_we=0, required 1"); end
                a0 = glb_addr;
                d0 = glb_wdata;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    checks++;
                    if (glb_we !== 1 || glb_addr !== a0 || glb_wdata !== d0 || opsum_ready !== 0) begin
                        errors++;
                        $display("FAIL bp_stall[%0d]: we=%b addr=%h data=%h ready=%b, required 1 %h %h 0", i, glb_we, glb_addr, glb_wdata, opsum_ready, a0, d0);
                    end
                end
                @(posedge clk); #1;
                glb_wready = 1;
            end
        join
        wait_done("bp", 3);
    endtask

    task automatic test_control();
        int f, l;
        start_job(16'h0500, 16'd0, 1, 0, 0);
        wait_done("num0", 0);
        checks++;
        if (busy !== 0) begin errors++; $display("FAIL num0_busy: got %b, required 0", busy); end
        sb.push_back('{16'h0020, 32'h06070809});
        start_job(16'h0020, 16'd4, 1, 0, 0);
        send_all('{9, 8}, f, l);
        cfg_base_addr = 16'h0080;
        cfg_num_opsum = 16'd1;
        cfg_start = 1;
        @(posedge clk); #1;
        cfg_start = 0;
        checks++;
        if (busy !== 1) begin errors++; $display("FAIL ignore_start_busy: got %b, required 1", busy); end
        send_all('{7, 6}, f, l);
        wait_done("ignore_start", 1);
        start_job(16'h0040, 16'd8, 1, 0, 0);
        send_all('{1, 2}, f, l);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks += 2;
        if (glb_we !== 0) begin errors++; $display("FAIL abort_we: got %b, required 0", glb_we); end
        if (busy !== 0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
        repeat (10) @(negedge clk);
        checks++;
        if (wr_cnt !== 0 || done_cnt !== 0) begin errors++; $display("FAIL abort_quiet: writes=%0d done=%0d, required 0 0", wr_cnt, done_cnt); end
        @(posedge clk); #1;
        push_expected(16'h0050, 2, 1, -3, '{10, -20, 30, -40, 50});
        start_job(16'h0050, 16'd5, 2, 1, -3);
        send_all('{10, -20, 30, -40, 50}, f, l);
        wait_done("after_abort", 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_pack();
        test_round_sat();
        test_partial_tail();
        test_backpressure();
        test_control();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/opsum_ppu.md
# opsum_ppu

Post-processing and writeback stage directly downstream of the PE array's opsum port. Consumes the 32-bit partial-sum stream that the array emits through its GLB opsum valid/ready interface. Requantizes each value to int8: scale multiply, rounding arithmetic shift, optional ReLU, zero-point add, saturation. Packs four results per 32-bit word and writes the words into the GLB at sequential addresses.

## Interface
- DATA_SIZE, 32, opsum width and GLB word width
- ADDR_BITS, 16, GLB word-address width and element-count width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- cfg_start  input  1  one-cycle pulse; latches all cfg_* and starts a job (honoured only in IDLE)
- cfg_base_addr  input  ADDR_BITS  first GLB word address
- cfg_num_opsum  input  ADDR_BITS  number of opsums in the job
- cfg_scale  input  16  unsigned multiplier
- cfg_shift  input  5  right-shift amount, 0..31
- cfg_zero_point  input  8  signed output zero point
- opsum_valid  input  1  from PE array
- opsum_ready  output  1  to PE array
- opsum_data  input  DATA_SIZE  signed psum
- glb_we  output  1  write request
- glb_wready  input  1  GLB accepts write when glb_we && glb_wready
- glb_addr  output  ADDR_BITS  word address
- glb_wdata  output  DATA_SIZE  packed int8 x4
- busy  output  1  high in RUN and FLUSH
- done  output  1  one-cycle pulse at job end

## Operation
- FSM: IDLE -> RUN on cfg_start. RUN -> FLUSH once cfg_num_opsum elements are accepted. FLUSH -> DONE when the pipeline is empty and the last word's write handshake completes. DONE -> IDLE after one cycle; done = 1 only in DONE.
- cfg_num_opsum = 0: IDLE -> DONE directly. No writes are issued.
- cfg_start while not IDLE is ignored.
- Input accepted on opsum_valid && opsum_ready.
- opsum_ready = (state==RUN) && (accepted < num) && !stall, where stall = glb_we && !glb_wready.
- Pipeline stage S1: p = signed(opsum_data) * signed({1'b0,cfg_scale}), 49-bit.
- Pipeline stage S2, step 1: r = (p + (shift ? 1<<(shift-1) : 0)) >>> shift. Add the rounding term before the shift; the shift is arithmetic.
- S2, step 2: ReLU when enabled (see Configuration).
- S2, step 3: y = r + sign-extended zero_point, computed at full width.
- S2, step 4: y saturates to [-128, 127].
- Packer: job element k goes to byte lane k%4, i.e. glb_wdata[8*(k%4)+:8].
- A word is written when lane 3 fills, or when the final element lands in any lane. Unused lanes of a partial word are 8'h00.
- glb_addr starts at cfg_base_addr and increments by 1 per completed write handshake. Wraps modulo 2^ADDR_BITS.
- While stalled, S1, S2 and the packer all hold. glb_we, glb_addr and glb_wdata stay stable until the handshake completes.

## Timing
- Reset values: opsum_ready=0, glb_we=0, glb_addr=0, glb_wdata=0, busy=0, done=0. State = IDLE; all counters and pipeline valids clear.
- Reset asserted mid-job aborts the job in the following cycle. No further writes and no done pulse occur.
- Latency: if the handshake of a word's final element is at cycle t, glb_we is high in cycle t+3 (with glb_wready high throughout).
- Throughput: 1 opsum/cycle with glb_wready held high. One write per 4 elements.
- busy rises the cycle after cfg_start and falls when the FSM enters DONE.
- done pulses in the cycle after the last write handshake.
- Simultaneous events in one cycle:
  - New input accepted while a write completes: both take effect.
  - Stall beginning while opsum_valid is high: opsum_ready is already low in that cycle, so no acceptance.

## Configuration
- Macro: OPSUM_PPU_RELU_EN.
- Defined: negative r is replaced by 0 before the zero-point add. Every output is therefore ≥ zero_point (after saturation).
- Undefined: there is no ReLU stage; negative r passes straight to the zero-point add and saturation.

## Test plan
- Basic pack:
  - Setup: base=0x0010, num=4, scale=1, shift=0, zp=0.
  - Stimulus: opsums 1, 2, 3, 4.
  - Required: one write, addr 0x0010, wdata 0x04030201, glb_we at t+3, then done.
- Rounding/saturation:
  - Setup: scale=3, shift=2, zp=0.
  - Stimulus: 5 gives 15→round 4; 1000 gives 750→127; -1000 gives -750→-128 (ReLU off).
  - Required: with OPSUM_PPU_RELU_EN, -1000 yields 0x00 and -3 with zp=5 yields 0x05.
- Partial tail:
  - Setup: num=6, base=0xFFFF, ADDR_BITS=16, scale=1, shift=0, zp=0.
  - Stimulus: opsums 1..6.
  - Required: two writes, to 0xFFFF and then 0x0000. The second word is 0x00000605.
- Backpressure:
  - Stimulus: glb_wready low for 5 cycles while the first word is pending.
  - Required: glb_we/addr/wdata stable; opsum_ready low; no data loss; final words match the unstalled run.
- Control edges:
  - Stimulus: num=0 job.
  - Required: done with zero writes.
  - Stimulus: cfg_start during RUN.
  - Required: ignored.
  - Stimulus: rst asserted after element 2 of 8.
  - Required: glb_we=0 next cycle, no done; a fresh job then completes correctly.
